pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised elastic pipeline register, the successor to the fixed-field inter-stage latches (F/D, D/E, E/M, M/W) of the five-stage MIPS core. It carries one packed stage bundle (IR, PC, PC+4, operands, immediates, HI/LO inputs) across a stage boundary. It adds a valid/ready handshake, a two-entry skid buffer so that `in_ready` is registered, and a synchronous flush that inserts an all-zero bubble (IR = 0 = `nop`).

## Interface
- `DATA_W`, 256: width of the packed stage bundle (8 × 32-bit fields).
- `CNT_W`, 32: width of the stall counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream stage offers `in_data`.
- `in_ready`  out  1  block can accept; driven directly from a register.
- `in_data`  in  DATA_W  bundle from upstream.
- `flush`  in  1  synchronous kill of all held entries (hazard/branch unit).
- `out_valid`  out  1  `out_data` holds a live bundle.
- `out_ready`  in  1  downstream stage consumes this cycle.
- `out_data`  out  DATA_W  bundle to downstream; all-zero when `out_valid`=0.
- `stall_cnt`  out  CNT_W  output-stall cycle count (see Configuration).

## Operation
- Storage: main entry (`m_valid`, `m_data`) drives the outputs. Skid entry (`s_valid`, `s_data`) is filled only when the main entry is blocked.
- Handshakes:
  - Input transfer `in_fire = in_valid & in_ready`.
  - Output transfer `out_fire = out_valid & out_ready`.
  - `in_ready = ~s_valid`. `out_valid = m_valid`.
- States: EMPTY (`m`=0, `s`=0), BUSY (`m`=1, `s`=0), FULL (`m`=1, `s`=1).
- EMPTY: `in_fire` → BUSY, `m_data<=in_data`. Otherwise stay.
- BUSY:
  - `in_fire & out_fire` → BUSY, `m_data<=in_data`.
  - `in_fire & ~out_fire` → FULL, `s_data<=in_data`.
  - `~in_fire & out_fire` → EMPTY, `m_data<=0`.
  - Neither → hold.
- FULL: `in_ready`=0, so no `in_fire` is possible.
  - `out_fire` → BUSY, `m_data<=s_data`, `s_data<=0`.
  - Otherwise hold.
- Flush (highest priority):
  - Next state is EMPTY; both data registers go to 0.
  - Any `in_fire` in the same cycle is discarded.
  - An `out_fire` in the same cycle still counts as delivered, because downstream sampled `out_data` that cycle.
- Ordering is strictly FIFO; no bundle is duplicated or dropped except by flush.
- Data is never combinationally passed from `in_data` to `out_data`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `m_valid`=`s_valid`=0, both data registers 0.
  - `out_valid`=0, `out_data`=0, `in_ready`=1, `stall_cnt`=0.
- Latency: a bundle accepted at edge N is presented on `out_data` with `out_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 bundle/cycle while `out_ready`=1.
- Backpressure:
  - When `out_ready` drops, one further bundle is absorbed into the skid entry.
  - `in_ready` falls after that edge.
  - `in_ready` returns to 1 one edge after the first `out_fire` from FULL.
- Drain from FULL with `out_ready`=1 continuously: skid bundle appears at `out_data` 1 cycle after the main bundle; state reaches EMPTY 2 edges later if no input arrives.
- Flush asserted at edge N: after edge N, `out_valid`=0, `out_data`=0, `in_ready`=1.
- Reset asserted mid-transfer: in-flight bundles are lost and outputs go to reset values immediately, with no clock needed.
- Hold: upstream may change `in_data` freely while `in_ready`=0. Downstream sees `out_data` stable while `out_valid & ~out_ready`.

## Configuration
- Macro `PIPE_STALL_CNT_EN`.
- Defined:
  - `stall_cnt` increments on every edge where `out_valid & ~out_ready`.
  - It saturates at all-ones (no wrap).
  - It is cleared only by reset; flush does not clear it.
- Undefined: the counter logic is absent and `stall_cnt` is tied to 0.

## Test plan
- Streaming: after reset, `out_ready`=1, push `in_data` = 1,2,3,4 on consecutive cycles → `out_data` = 1,2,3,4 on the following consecutive cycles, `in_ready` constantly 1.
- Backpressure: push 0xA,0xB,0xC with `out_ready`=0 → 0xA in main, 0xB in skid, `in_ready`=0. Raise `out_ready` → outputs 0xA,0xB,0xC in order, with 0xC accepted only after `in_ready` reasserts.
- Flush in FULL: hold 0x11/0x22 in FULL, assert `flush` together with `in_valid`, `in_data`=0x33 → next cycle `out_valid`=0, `out_data`=0, `in_ready`=1, and 0x33 never appears.
- Flush with simultaneous `out_fire` in BUSY holding 0x55 → 0x55 counted as consumed once; EMPTY afterwards.
- Async reset mid-burst: assert `reset` between clock edges while FULL → `out_valid`, `out_data`, `stall_cnt` go to 0 and `in_ready` to 1 before the next edge.
- With `PIPE_STALL_CNT_EN`, `CNT_W`=4: hold one bundle with `out_ready`=0 for 20 cycles → `stall_cnt`=15 (saturated). Without the macro → `stall_cnt`=0.

Source files
------------

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: the upstream valid/ready/data triple,
// the flush strobe, the downstream valid/ready/data triple and the stall count.
// The slave modport is the register's own view; master is the driving
// environment (the neighbouring pipeline stages or a bench).
interface pipe_skid_reg_if #(
    parameter int DATA_W = 256,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid,
        output in_data,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  stall_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output stall_cnt
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic inter-stage register with a two-entry skid buffer.
// The main entry drives the outputs; the skid entry catches the one bundle
// that arrives in the cycle downstream stops accepting, so in_ready can come
// straight from a flop. Flush empties both entries and leaves a zero bubble.
// Optional feature: define PIPE_STALL_CNT_EN to build the saturating
// output-stall counter; otherwise stall_cnt is tied to zero.
module pipe_skid_reg #(
    parameter int DATA_W = 256,
    parameter int CNT_W  = 32
) (
    input logic             clk,
    input logic             reset,
    pipe_skid_reg_if.slave  bus
);

    // Bit 0 = main entry valid, bit 1 = skid entry valid, so both handshake
    // outputs are single state bits with no decode.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              in_fire;
    logic              out_fire;

    assign bus.in_ready  = ~state_q[1];
    assign bus.out_valid = state_q[0];
    // Main data is zeroed whenever the main entry empties, so no output mask.
    assign bus.out_data  = m_data_q;

    assign in_fire  = bus.in_valid & ~state_q[1];
    assign out_fire = state_q[0] & bus.out_ready;

    // State and data registers; reset clears everything without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            s_data_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
        end
    end

    // Next-state and data steering; flush overrides every transfer but an
    // out_fire in the same cycle has already been sampled downstream.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (bus.flush) begin
            state_d  = EMPTY;
            m_data_d = '0;
            s_data_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d  = BUSY;
                        m_data_d = bus.in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        m_data_d = bus.in_data;
                    end else if (in_fire) begin
                        state_d  = FULL;
                        s_data_d = bus.in_data;
                    end else if (out_fire) begin
                        state_d  = EMPTY;
                        m_data_d = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_d  = BUSY;
                        m_data_d = s_data_q;
                        s_data_d = '0;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    m_data_d = '0;
                    s_data_d = '0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a live bundle is refused downstream, sticking at max.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q[0] && !bus.out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Stall counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a depth-2 FIFO reference model checked against the
// DUT on every falling edge, directed scenarios with literal expectations,
// then randomized traffic with random flushes and backpressure.
module tb_pipe_skid_reg;
    localparam int DATA_W = 256;
    localparam int CNT_W  = 4;

    logic clk;
    logic reset;

    pipe_skid_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fire55   = 0;
    logic cmp_en = 1'b0;

    // Reference model: the register behaves as a FIFO of at most two bundles.
    logic [DATA_W-1:0] mq[$];
    logic [CNT_W-1:0]  m_cnt;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model update on each edge, using the inputs as they stand at the edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_cnt <= '0;
        end else begin
`ifdef PIPE_STALL_CNT_EN
            if (mq.size() > 0 && !bus.out_ready && m_cnt != {CNT_W{1'b1}})
                m_cnt <= m_cnt + 1'b1;
`endif
            if (bus.flush) begin
                mq.delete();
            end else begin
                logic do_in;
                logic do_out;
                do_in  = bus.in_valid && (mq.size() < 2);
                do_out = (mq.size() > 0) && bus.out_ready;
                if (do_out) void'(mq.pop_front());
                if (do_in) mq.push_back(bus.in_data);
            end
        end
    end

    // Count deliveries of the 0x55 bundle used in the flush-with-drain case.
    always @(posedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready && bus.out_data == DATA_W'(32'h55))
            fire55 <= fire55 + 1;
    end

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (!reset && cmp_en) begin
            chk("cmp_out_valid", DATA_W'(bus.out_valid), DATA_W'(mq.size() > 0));
            chk("cmp_out_data", bus.out_data, (mq.size() > 0) ? mq[0] : '0);
            chk("cmp_in_ready", DATA_W'(bus.in_ready), DATA_W'(mq.size() < 2));
            chk("cmp_stall_cnt", DATA_W'(bus.stall_cnt), DATA_W'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic f, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
    endtask

    task automatic lit(input string name, input logic ov, input logic [DATA_W-1:0] od,
                       input logic ir);
        chk({name, "_out_valid"}, DATA_W'(bus.out_valid), DATA_W'(ov));
        chk({name, "_out_data"}, bus.out_data, od);
        chk({name, "_in_ready"}, DATA_W'(bus.in_ready), DATA_W'(ir));
    endtask

    function automatic logic [DATA_W-1:0] rand_bundle();
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [CNT_W-1:0] sat_exp;

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        lit("reset", 1'b0, '0, 1'b1);
        chk("reset_stall_cnt", DATA_W'(bus.stall_cnt), '0);
        tick();
        tick();
        reset = 1'b0;
        cmp_en = 1'b1;

        // Streaming 1..4 with out_ready high.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DATA_W'(i), 1'b0, 1'b1);
            tick();
            lit($sformatf("stream%0d", i), 1'b1, DATA_W'(i), 1'b1);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        lit("stream_end", 1'b0, '0, 1'b1);

        // Backpressure: A into main, B into skid, C waits for in_ready.
        drive(1'b1, DATA_W'(32'hA), 1'b0, 1'b0);
        tick();
        lit("bp_a", 1'b1, DATA_W'(32'hA), 1'b1);
        drive(1'b1, DATA_W'(32'hB), 1'b0, 1'b0);
        tick();
        lit("bp_full", 1'b1, DATA_W'(32'hA), 1'b0);
        drive(1'b1, DATA_W'(32'hC), 1'b0, 1'b0);
        tick();
        lit("bp_hold", 1'b1, DATA_W'(32'hA), 1'b0);
        drive(1'b1, DATA_W'(32'hC), 1'b0, 1'b1);
        tick();
        lit("bp_b", 1'b1, DATA_W'(32'hB), 1'b1);
        tick();
        lit("bp_c", 1'b1, DATA_W'(32'hC), 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        lit("bp_end", 1'b0, '0, 1'b1);

        // Flush while FULL with a concurrent offer of 0x33.
        drive(1'b1, DATA_W'(32'h11), 1'b0, 1'b0);
        tick();
        drive(1'b1, DATA_W'(32'h22), 1'b0, 1'b0);
        tick();
        lit("fl_full", 1'b1, DATA_W'(32'h11), 1'b0);
        drive(1'b1, DATA_W'(32'h33), 1'b1, 1'b0);
        tick();
        lit("fl_after", 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        tick();
        lit("fl_no33", 1'b0, '0, 1'b1);

        // Flush in BUSY together with the consumer taking 0x55.
        drive(1'b1, DATA_W'(32'h55), 1'b0, 1'b0);
        tick();
        lit("fb_busy", 1'b1, DATA_W'(32'h55), 1'b1);
        drive(1'b0, '0, 1'b1, 1'b1);
        tick();
        lit("fb_after", 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        chk("fb_delivered_once", DATA_W'(fire55), DATA_W'(1));

        // Stall counter: one bundle refused for 20 cycles.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        drive(1'b1, DATA_W'(32'h77), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
`ifdef PIPE_STALL_CNT_EN
        sat_exp = 4'd15;
`else
        sat_exp = 4'd0;
`endif
        chk("stall_saturate", DATA_W'(bus.stall_cnt), DATA_W'(sat_exp));
        lit("stall_hold", 1'b1, DATA_W'(32'h77), 1'b1);

        // Asynchronous reset between edges while FULL.
        drive(1'b1, DATA_W'(32'h88), 1'b0, 1'b0);
        tick();
        lit("ar_full", 1'b1, DATA_W'(32'h77), 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        lit("ar_now", 1'b0, '0, 1'b1);
        chk("ar_stall_cnt", DATA_W'(bus.stall_cnt), '0);
        tick();
        reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), rand_bundle(),
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        tick();
        lit("rand_drain", 1'b0, '0, 1'b1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
